q_argmax_seq: RTL and testbench
===============================

Name: q_argmax_seq

Overview:
- Sequential arg-max selector for the tic-tac-toe Q-learning agent.
- Consumes the 9 per-cell Q-values of one board state, streamed one per beat with a per-cell legality flag.
- Returns the index of the best legal cell together with its Q-value.
- Sits between the Q-table read port and the move/commit logic. It turns a max-Q search into the chosen action.

Parameters:
- DATA_W, 18: Q-value width; values are unsigned.
- N_ACT, 9: beats per search, one per board cell, in index order 0..N_ACT-1.
- IDX_W, 4: width of the cell index; must satisfy 2^IDX_W >= N_ACT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept a beat.
- s_q  input  DATA_W  Q-value of the current cell.
- s_legal  input  1  1 = cell empty, so the move is allowed.
- m_valid  output  1  result valid; held until accepted.
- m_ready  input  1  downstream accepts the result.
- m_idx  output  IDX_W  index of the best legal cell.
- m_q  output  DATA_W  Q-value of that cell.
- m_none  output  1  no legal cell existed in the search.

Behaviour:
- Reset is asynchronous, active-high. While rst is high: state=COLLECT, beat count=0, best_q=0, best_idx=0, have_best=0, m_valid=0, m_idx=0, m_q=0, m_none=0, s_ready=0. s_ready goes to 1 on the first clock edge after rst deasserts.
- There are two states.
- COLLECT:
  - s_ready=1.
  - A beat is accepted on s_valid && s_ready at a rising edge. Its index equals the current beat count (0..N_ACT-1).
  - An accepted legal beat replaces the running best if have_best==0 or s_q > best_q (unsigned, strict).
  - Ties keep the earlier, lower index. Illegal beats never touch best_q or best_idx, whatever their value.
  - The count increments by one per accepted beat.
  - On accepting beat N_ACT-1, the block moves to DONE. On that same edge it registers m_idx/m_q from the updated best (including the final beat) and sets m_none = !have_best_after_update.
- DONE:
  - m_valid=1 and s_ready=0. m_idx, m_q and m_none are stable while m_valid && !m_ready.
  - On m_valid && m_ready at an edge, the block returns to COLLECT: count=0, have_best=0, best_q=0, best_idx=0, m_valid=0.
  - m_idx, m_q and m_none keep their last values; they are don't-care while m_valid=0 but are not cleared.
  - s_ready rises the cycle after the handshake, so there is no same-cycle turnaround.
- Latency: m_valid is asserted the cycle after the final beat's acceptance edge. Best-case throughput is one search per N_ACT+1 cycles.
- If there is no legal cell: m_none=1, m_idx=0, m_q=0.
- Gaps (s_valid low mid-search) stall accumulation indefinitely; the count and best state are held.
- s_q and s_legal are sampled only on accepted beats. Values on non-accepted cycles have no effect.
- The count wraps only via the DONE path. It never exceeds N_ACT-1 in COLLECT.
- Reset asserted mid-search or in DONE aborts immediately to the reset values. The partial search is discarded and no result is emitted.
- All outputs are registered. There is no combinational path from s_* to m_* or from m_ready to s_ready.

Test Plan:
- Basic: rst pulse, then 9 legal beats q={5,40,7,40,3,0,12,39,1} -> one cycle after beat 8, m_valid=1, m_idx=1, m_q=40, m_none=0 (tie at idx 3 rejected).
- Legality mask: q={100,2,3,4,5,6,7,8,9}, legal=0 for idx 0 and idx 8 only -> m_idx=7, m_q=8. Then all illegal -> m_none=1, m_idx=0, m_q=0.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid -> outputs are stable and s_ready=0 throughout. Assert m_ready -> m_valid drops next edge, s_ready=1 that cycle, and a second search with max 0x3FFFF at idx 8 returns m_idx=8, m_q=0x3FFFF.
- Stalls: s_valid toggled 1/0 randomly across 9 beats with q=index*3, all legal -> m_idx=8, m_q=24. The result is identical to the gap-free run.
- Reset mid-operation: assert rst asynchronously (between edges) after beat 4 -> outputs go to reset values immediately. After release, a fresh 9-beat search returns a result computed only from the new beats.

Source files
------------

// File: rtl/q_argmax_seq.sv
// Sequential arg-max over N_ACT streamed Q-values with per-cell legality.
// Emits the lowest-index legal cell holding the largest Q-value, or m_none when no cell is legal.
module q_argmax_seq #(
   parameter int DATA_W = 18,
   parameter int N_ACT  = 9,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_q,
   input  logic              s_legal,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [IDX_W-1:0]  m_idx,
   output logic [DATA_W-1:0] m_q,
   output logic              m_none
);

   localparam logic [0:0]       ST_COLLECT = 1'b0;
   localparam logic [0:0]       ST_DONE    = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ACT - 1);

   logic [0:0]        state_p0;
   logic [IDX_W-1:0]  cnt_p0;
   logic [DATA_W-1:0] best_q_p0;
   logic [IDX_W-1:0]  best_idx_p0;
   logic              have_best_p0;

   logic              accept;
   logic              take;
   logic              last_beat;
   logic [DATA_W-1:0] nxt_q;
   logic [IDX_W-1:0]  nxt_idx;
   logic              nxt_have;

   // Strict compare keeps the earlier index on ties.
   function automatic logic beats_best(input logic [DATA_W-1:0] cand,
                                       input logic [DATA_W-1:0] cur,
                                       input logic              have);
      return !have || (cand > cur);
   endfunction

   always_comb begin
      accept    = (state_p0 == ST_COLLECT) && s_valid && s_ready;
      take      = accept && s_legal && beats_best(s_q, best_q_p0, have_best_p0);
      last_beat = accept && (cnt_p0 == LAST_IDX);
      nxt_q     = take ? s_q : best_q_p0;
      nxt_idx   = take ? cnt_p0 : best_idx_p0;
      nxt_have  = have_best_p0 | (accept & s_legal);
   end

   // Stage p0: running best and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0     <= ST_COLLECT;
         cnt_p0       <= '0;
         best_q_p0    <= '0;
         best_idx_p0  <= '0;
         have_best_p0 <= 1'b0;
         s_ready      <= 1'b0;
         m_valid      <= 1'b0;
         m_idx        <= '0;
         m_q          <= '0;
         m_none       <= 1'b0;
      end else begin
         case (state_p0)
            ST_COLLECT: begin
               s_ready <= !last_beat;
               if (accept) begin
                  best_q_p0    <= nxt_q;
                  best_idx_p0  <= nxt_idx;
                  have_best_p0 <= nxt_have;
                  if (last_beat) begin
                     state_p0 <= ST_DONE;
                     m_valid  <= 1'b1;
                     m_idx    <= nxt_idx;
                     m_q      <= nxt_q;
                     m_none   <= !nxt_have;
                  end else begin
                     cnt_p0 <= cnt_p0 + IDX_W'(1);
                  end
               end
            end
            default: begin
               s_ready <= 1'b0;
               if (m_ready) begin
                  // Result fields are left as-is; only control and accumulator clear.
                  state_p0     <= ST_COLLECT;
                  cnt_p0       <= '0;
                  best_q_p0    <= '0;
                  best_idx_p0  <= '0;
                  have_best_p0 <= 1'b0;
                  m_valid      <= 1'b0;
                  s_ready      <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_argmax_seq.sv
// Bench for q_argmax_seq: directed table, randomized searches against an arg-max model, reset abort.
module tb_q_argmax_seq;

   localparam int DATA_W = 18;
   localparam int N_ACT  = 9;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_q;
   logic              s_legal;
   logic              m_valid;
   logic              m_ready;
   logic [IDX_W-1:0]  m_idx;
   logic [DATA_W-1:0] m_q;
   logic              m_none;

   always #5 clk = ~clk;

   q_argmax_seq #(.DATA_W(DATA_W), .N_ACT(N_ACT), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_q(s_q), .s_legal(s_legal),
      .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_q(m_q), .m_none(m_none)
   );

   typedef struct packed {
      logic [N_ACT-1:0][DATA_W-1:0] q;
      logic [N_ACT-1:0]             legal;
      logic                         gaps;
      logic [3:0]                   hold;
      logic [IDX_W-1:0]             e_idx;
      logic [DATA_W-1:0]            e_q;
      logic                         e_none;
   } vec_t;

   typedef int qarr_t [N_ACT];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input qarr_t qa, input logic [N_ACT-1:0] legal, input logic gaps,
                               input int hold, input int e_idx, input int e_q, input logic e_none);
      vec_t v;
      for (int i = 0; i < N_ACT; i++) v.q[i] = DATA_W'(qa[i]);
      v.legal  = legal;
      v.gaps   = gaps;
      v.hold   = 4'(hold);
      v.e_idx  = IDX_W'(e_idx);
      v.e_q    = DATA_W'(e_q);
      v.e_none = e_none;
      return v;
   endfunction

   // Reference: first index reaching the maximum Q among legal cells.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int   best = -1;
      int   bq   = 0;
      for (int i = 0; i < N_ACT; i++) begin
         if (v.legal[i] && (best < 0 || int'(v.q[i]) > bq)) begin
            best = i;
            bq   = int'(v.q[i]);
         end
      end
      r.e_none = (best < 0);
      r.e_idx  = (best < 0) ? '0 : IDX_W'(best);
      r.e_q    = (best < 0) ? '0 : DATA_W'(bq);
      return r;
   endfunction

   task automatic drive_beats(input vec_t v, input int n);
      int guard;
      for (int i = 0; i < n; i++) begin
         if (v.gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               s_valid = 1'b0;
               s_q     = DATA_W'($urandom);
               s_legal = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         s_valid = 1'b1;
         s_q     = v.q[i];
         s_legal = v.legal[i];
         guard   = 0;
         while (!s_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
         if (i == N_ACT - 1) chk("early_m_valid", 32'(m_valid), 32'd0);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_q     = DATA_W'($urandom);
      s_legal = 1'($urandom);
   endtask

   task automatic run_search(input vec_t v, input string tag);
      drive_beats(v, N_ACT);
      chk({tag, "_latency_m_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_done_s_ready"}, 32'(s_ready), 32'd0);
      for (int h = 0; h < int'(v.hold); h++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_m_valid"}, 32'(m_valid), 32'd1);
         chk({tag, "_hold_s_ready"}, 32'(s_ready), 32'd0);
         chk({tag, "_hold_m_idx"}, 32'(m_idx), 32'(v.e_idx));
         chk({tag, "_hold_m_q"}, 32'(m_q), 32'(v.e_q));
      end
      chk({tag, "_m_idx"}, 32'(m_idx), 32'(v.e_idx));
      chk({tag, "_m_q"}, 32'(m_q), 32'(v.e_q));
      chk({tag, "_m_none"}, 32'(m_none), 32'(v.e_none));
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk({tag, "_release_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_release_s_ready"}, 32'(s_ready), 32'd1);
   endtask

   vec_t  tbl [7];
   vec_t  v;
   qarr_t a;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_q = '0; s_legal = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_idx", 32'(m_idx), 32'd0);
      chk("rst_m_q", 32'(m_q), 32'd0);
      chk("rst_m_none", 32'(m_none), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);

      a = '{5, 40, 7, 40, 3, 0, 12, 39, 1};
      tbl[0] = mk(a, 9'h1FF, 1'b0, 0, 1, 40, 1'b0);
      a = '{100, 2, 3, 4, 5, 6, 7, 8, 9};
      tbl[1] = mk(a, 9'b011111110, 1'b0, 0, 7, 8, 1'b0);
      tbl[2] = mk(a, 9'b000000000, 1'b0, 0, 0, 0, 1'b1);
      a = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
      tbl[3] = mk(a, 9'h1FF, 1'b0, 5, 0, 9, 1'b0);
      a = '{1, 2, 3, 4, 5, 6, 7, 8, 262143};
      tbl[4] = mk(a, 9'h1FF, 1'b0, 0, 8, 262143, 1'b0);
      a = '{0, 3, 6, 9, 12, 15, 18, 21, 24};
      tbl[5] = mk(a, 9'h1FF, 1'b0, 0, 8, 24, 1'b0);
      tbl[6] = mk(a, 9'h1FF, 1'b1, 0, 8, 24, 1'b0);

      for (int t = 0; t < 7; t++) run_search(tbl[t], $sformatf("vec%0d", t));

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N_ACT; i++)
            v.q[i] = (r % 2 == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
         v.legal = N_ACT'($urandom);
         v.gaps  = 1'($urandom);
         v.hold  = 4'($urandom_range(0, 3));
         v = model(v);
         run_search(v, $sformatf("rnd%0d", r));
      end

      // Abort mid-search: the large value at idx 2 must not leak into the next result.
      run_search(tbl[0], "pre_abort");
      a = '{10, 20, 262143, 30, 40, 0, 0, 0, 0};
      v = mk(a, 9'h1FF, 1'b0, 0, 0, 0, 1'b0);
      drive_beats(v, 5);
      #2 rst = 1'b1;
      #1;
      chk("abort_m_valid", 32'(m_valid), 32'd0);
      chk("abort_s_ready", 32'(s_ready), 32'd0);
      chk("abort_m_idx", 32'(m_idx), 32'd0);
      chk("abort_m_q", 32'(m_q), 32'd0);
      chk("abort_m_none", 32'(m_none), 32'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_release_s_ready", 32'(s_ready), 32'd1);
      for (int i = 0; i < N_ACT; i++) v.q[i] = DATA_W'($urandom_range(0, 1000));
      v.legal = 9'b101010110;
      v.gaps  = 1'b0;
      v.hold  = 4'd1;
      v = model(v);
      run_search(v, "post_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
